// File: rtl/cache_pkg.sv
// Shared types and constants for the L1 data cache miss/fill sequencer.
package cache_pkg;

  localparam int unsigned TAG_BITS         = 14;
  localparam int unsigned IDX_BITS         = 13;
  localparam int unsigned WAYS             = 4;
  localparam int unsigned LINE_BITS        = 256;
  localparam int unsigned LINE_OFFSET_BITS = 5;
  localparam int unsigned ADDR_BITS        = 32;
  localparam int unsigned BIT_CMD_BITS     = 4;

  typedef enum logic [2:0] {
    IDLE,
    EVICT,
    FILL,
    FILLWR,
    REPLAY
  } state_t;

  localparam logic [BIT_CMD_BITS-1:0] BIT_NOP     = 4'd0;
  localparam logic [BIT_CMD_BITS-1:0] BIT_SET_MOD = 4'd1;
  localparam logic [BIT_CMD_BITS-1:0] BIT_FILL    = 4'd2;

  // Line-aligned main-memory address from a tag and set index.
  function automatic logic [ADDR_BITS-1:0] mm_addr(input logic [TAG_BITS-1:0] tag,
                                                   input logic [IDX_BITS-1:0] idx);
    return {tag, idx, {LINE_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/victim_sel.sv
// Victim way selection: first invalid way, else tree-PLRU over 4 ways.
module victim_sel
  import cache_pkg::*;
(
  input  logic [WAYS-1:0] val_out,
  input  logic [2:0]      lru,
  output logic [WAYS-1:0] way
);

  always_comb begin
    way = '0;
    if (!val_out[0]) begin
      way = 4'b0001;
    end else if (!val_out[1]) begin
      way = 4'b0010;
    end else if (!val_out[2]) begin
      way = 4'b0100;
    end else if (!val_out[3]) begin
      way = 4'b1000;
    end else if (!lru[0]) begin
      way = lru[1] ? 4'b0010 : 4'b0001;
    end else begin
      way = lru[2] ? 4'b1000 : 4'b0100;
    end
  end

endmodule

// File: rtl/miss_ctrl.sv
// Miss/fill/eviction sequencer for the 4-way write-back, write-allocate L1 D-cache.
module miss_ctrl
  import cache_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pe_access,
  input  logic                       pe_read,
  input  logic                       pe_write,
  input  logic                       req_hit,
  input  logic [TAG_BITS-1:0]        pe_tag,
  input  logic [IDX_BITS-1:0]        pe_index,
  input  logic [WAYS-1:0]            val_out,
  input  logic [WAYS-1:0]            mod_out,
  input  logic [2:0]                 lru,
  input  logic [WAYS*TAG_BITS-1:0]   tag_out,
  input  logic [LINE_BITS-1:0]       mm_rd,
  input  logic                       mm_valid,
  output logic                       stall,
  output logic [ADDR_BITS-1:0]       mm_a,
  output logic                       mm_read,
  output logic                       mm_write,
  output logic [WAYS-1:0]            evict_way,
  output logic [LINE_BITS-1:0]       fill_data,
  output logic                       fsm_cc_fill,
  output logic                       fsm_cc_ary_write,
  output logic [WAYS-1:0]            fsm_cc_tag_write,
  output logic [BIT_CMD_BITS-1:0]    fsm_bit_cmd,
  output logic                       fsm_bit_cmd_valid
);

  state_t                state_q, state_d;
  logic [WAYS-1:0]       vway_q, vway_d;
  logic [TAG_BITS-1:0]   vtag_q, vtag_d;
  logic [LINE_BITS-1:0]  fill_data_q, fill_data_d;

  logic [WAYS-1:0]       victim;
  logic [TAG_BITS-1:0]   victim_tag;
  logic                  victim_dirty;
  logic                  miss;
  logic                  unused_ok;

  // Read vs write only matters on the hit path, where pe_write alone decides.
  assign unused_ok = pe_read;

  victim_sel u_victim_sel (
    .val_out (val_out),
    .lru     (lru),
    .way     (victim)
  );

  assign miss         = pe_access & ~req_hit;
  assign victim_dirty = |(victim & mod_out & val_out);

  always_comb begin
    victim_tag = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (victim[w]) victim_tag = victim_tag | tag_out[w*TAG_BITS +: TAG_BITS];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      vway_q      <= '0;
      vtag_q      <= '0;
      fill_data_q <= '0;
    end else begin
      state_q     <= state_d;
      vway_q      <= vway_d;
      vtag_q      <= vtag_d;
      fill_data_q <= fill_data_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    vway_d            = vway_q;
    vtag_d            = vtag_q;
    fill_data_d       = fill_data_q;
    mm_read           = 1'b0;
    mm_write          = 1'b0;
    mm_a              = '0;
    evict_way         = '0;
    fsm_cc_fill       = 1'b0;
    fsm_cc_ary_write  = 1'b0;
    fsm_cc_tag_write  = '0;
    fsm_bit_cmd       = BIT_NOP;
    fsm_bit_cmd_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss) begin
          // Victim and its tag are frozen here; the PE holds the index from now on.
          vway_d  = victim;
          vtag_d  = victim_tag;
          state_d = victim_dirty ? EVICT : FILL;
        end else if (pe_access && pe_write) begin
          fsm_cc_ary_write  = 1'b1;
          fsm_bit_cmd       = BIT_SET_MOD;
          fsm_bit_cmd_valid = 1'b1;
        end
      end
      EVICT: begin
        mm_write  = 1'b1;
        mm_a      = mm_addr(vtag_q, pe_index);
        evict_way = vway_q;
        if (mm_valid) state_d = FILL;
      end
      FILL: begin
        mm_read = 1'b1;
        mm_a    = mm_addr(pe_tag, pe_index);
        if (mm_valid) begin
          fill_data_d = mm_rd;
          state_d     = FILLWR;
        end
      end
      FILLWR: begin
        fsm_cc_fill       = 1'b1;
        fsm_cc_ary_write  = 1'b1;
        fsm_cc_tag_write  = vway_q;
        fsm_bit_cmd       = BIT_FILL;
        fsm_bit_cmd_valid = 1'b1;
        state_d           = REPLAY;
      end
      REPLAY: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign stall     = miss | (state_q != IDLE);
  assign fill_data = fill_data_q;

endmodule

// File: tb/tb_miss_ctrl.sv
// Scoreboard bench for miss_ctrl: directed miss/hit sequences against hand-computed events.
module tb_miss_ctrl;
  import cache_pkg::*;

  localparam int LAT = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     pe_access, pe_read, pe_write, req_hit;
  logic [TAG_BITS-1:0]      pe_tag;
  logic [IDX_BITS-1:0]      pe_index;
  logic [WAYS-1:0]          val_out, mod_out;
  logic [2:0]               lru;
  logic [WAYS*TAG_BITS-1:0] tag_out;
  logic [LINE_BITS-1:0]     mm_rd;
  logic                     mm_valid;
  logic                     stall;
  logic [ADDR_BITS-1:0]     mm_a;
  logic                     mm_read, mm_write;
  logic [WAYS-1:0]          evict_way;
  logic [LINE_BITS-1:0]     fill_data;
  logic                     fsm_cc_fill, fsm_cc_ary_write;
  logic [WAYS-1:0]          fsm_cc_tag_write;
  logic [BIT_CMD_BITS-1:0]  fsm_bit_cmd;
  logic                     fsm_bit_cmd_valid;

  logic resp_en, resp_valid, inj_valid;
  int   resp_cnt;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic        stall;
    logic        mm_read;
    logic        mm_write;
    logic [31:0] mm_a;
    logic [3:0]  evict_way;
    logic        fill;
    logic        ary_write;
    logic [3:0]  tag_write;
    logic [3:0]  bit_cmd;
    logic        bit_valid;
    logic [255:0] line;
  } ev_t;

  ev_t exp_q[$];

  miss_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .pe_access         (pe_access),
    .pe_read           (pe_read),
    .pe_write          (pe_write),
    .req_hit           (req_hit),
    .pe_tag            (pe_tag),
    .pe_index          (pe_index),
    .val_out           (val_out),
    .mod_out           (mod_out),
    .lru               (lru),
    .tag_out           (tag_out),
    .mm_rd             (mm_rd),
    .mm_valid          (mm_valid),
    .stall             (stall),
    .mm_a              (mm_a),
    .mm_read           (mm_read),
    .mm_write          (mm_write),
    .evict_way         (evict_way),
    .fill_data         (fill_data),
    .fsm_cc_fill       (fsm_cc_fill),
    .fsm_cc_ary_write  (fsm_cc_ary_write),
    .fsm_cc_tag_write  (fsm_cc_tag_write),
    .fsm_bit_cmd       (fsm_bit_cmd),
    .fsm_bit_cmd_valid (fsm_bit_cmd_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign mm_valid = resp_valid | inj_valid;

  // Main memory: completes each request after it has been held LAT cycles.
  always @(negedge clk) begin
    resp_valid = 1'b0;
    if (reset) begin
      resp_cnt = 0;
    end else if (resp_en && (mm_read || mm_write)) begin
      resp_cnt++;
      if (resp_cnt == LAT) begin
        resp_valid = 1'b1;
        resp_cnt   = 0;
      end
    end
  end

  // Monitor: every cycle with any active output must match the next expected event.
  always @(negedge clk) begin
    ev_t got_e, exp_e;
    if (stall | mm_read | mm_write | fsm_cc_fill | fsm_cc_ary_write | fsm_bit_cmd_valid |
        (|evict_way) | (|fsm_cc_tag_write) | (|mm_a) | (|fsm_bit_cmd)) begin
      got_e.stall     = stall;
      got_e.mm_read   = mm_read;
      got_e.mm_write  = mm_write;
      got_e.mm_a      = mm_a;
      got_e.evict_way = evict_way;
      got_e.fill      = fsm_cc_fill;
      got_e.ary_write = fsm_cc_ary_write;
      got_e.tag_write = fsm_cc_tag_write;
      got_e.bit_cmd   = fsm_bit_cmd;
      got_e.bit_valid = fsm_bit_cmd_valid;
      got_e.line      = fsm_cc_fill ? fill_data : '0;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d stall=%b rd=%b wr=%b a=%h ev=%b fill=%b aw=%b tw=%b cmd=%h v=%b",
                 cyc, stall, mm_read, mm_write, mm_a, evict_way, fsm_cc_fill, fsm_cc_ary_write,
                 fsm_cc_tag_write, fsm_bit_cmd, fsm_bit_cmd_valid);
      end else begin
        exp_e = exp_q.pop_front();
        if (got_e !== exp_e) begin
          errors++;
          $display("FAIL event cyc=%0d got stall=%b rd=%b wr=%b a=%h ev=%b fill=%b aw=%b tw=%b cmd=%h v=%b line=%h | want stall=%b rd=%b wr=%b a=%h ev=%b fill=%b aw=%b tw=%b cmd=%h v=%b line=%h",
                   cyc, got_e.stall, got_e.mm_read, got_e.mm_write, got_e.mm_a, got_e.evict_way,
                   got_e.fill, got_e.ary_write, got_e.tag_write, got_e.bit_cmd, got_e.bit_valid, got_e.line,
                   exp_e.stall, exp_e.mm_read, exp_e.mm_write, exp_e.mm_a, exp_e.evict_way,
                   exp_e.fill, exp_e.ary_write, exp_e.tag_write, exp_e.bit_cmd, exp_e.bit_valid, exp_e.line);
        end
      end
    end
  end

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_stall();
    ev_t e;
    e       = '0;
    e.stall = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic push_mm(input logic rd, input logic [31:0] a, input logic [3:0] ev, input int n);
    ev_t e;
    e           = '0;
    e.stall     = 1'b1;
    e.mm_read   = rd;
    e.mm_write  = ~rd;
    e.mm_a      = a;
    e.evict_way = ev;
    repeat (n) exp_q.push_back(e);
  endtask

  task automatic push_fillwr(input logic [3:0] way, input logic [255:0] line);
    ev_t e;
    e           = '0;
    e.stall     = 1'b1;
    e.fill      = 1'b1;
    e.ary_write = 1'b1;
    e.tag_write = way;
    e.bit_cmd   = 4'd2;
    e.bit_valid = 1'b1;
    e.line      = line;
    exp_q.push_back(e);
  endtask

  task automatic push_hitwr();
    ev_t e;
    e           = '0;
    e.ary_write = 1'b1;
    e.bit_cmd   = 4'd1;
    e.bit_valid = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic outputs_zero(input string name);
    check(name, 256'({stall, mm_read, mm_write, mm_a, evict_way, fsm_cc_fill, fsm_cc_ary_write,
                      fsm_cc_tag_write, fsm_bit_cmd, fsm_bit_cmd_valid}), 256'(0));
    check({name, "_fill_data"}, fill_data, 256'(0));
  endtask

  // Issue one miss at the current cycle, act as the arrays, and finish on the replayed hit.
  task automatic do_miss(input logic wr, input logic [13:0] tag, input logic [12:0] idx,
                         input logic [3:0] val, input logic [3:0] mod, input logic [2:0] l,
                         input logic [55:0] tags, input logic [255:0] line,
                         input logic [3:0] exp_way, input logic dirty,
                         input logic [31:0] evict_a, input logic [31:0] fill_a, input int hit_delay);
    int c0;
    bit seen;
    push_stall();
    if (dirty) push_mm(1'b0, evict_a, exp_way, LAT);
    push_mm(1'b1, fill_a, 4'b0000, LAT);
    push_fillwr(exp_way, line);
    push_stall();
    if (wr) push_hitwr();
    pe_access = 1'b1;
    pe_read   = ~wr;
    pe_write  = wr;
    req_hit   = 1'b0;
    pe_tag    = tag;
    pe_index  = idx;
    val_out   = val;
    mod_out   = mod;
    lru       = l;
    tag_out   = tags;
    mm_rd     = line;
    c0        = cyc;
    seen      = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (|fsm_cc_tag_write) seen = 1'b1;
    end
    check("fillwr_reached", 256'(seen), 256'(1));
    tick();
    req_hit = 1'b1;
    tick();
    @(negedge clk);
    check("hit_stall", 256'(stall), 256'(0));
    check("hit_delay", 256'(cyc - c0), 256'(hit_delay));
    tick();
    pe_access = 1'b0;
    pe_read   = 1'b0;
    pe_write  = 1'b0;
    req_hit   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] lru_tab [4];
    logic [3:0] way_tab [4];
    lru_tab = '{3'b000, 3'b010, 3'b001, 3'b101};
    way_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    reset = 1'b1;
    pe_access = 1'b0; pe_read = 1'b0; pe_write = 1'b0; req_hit = 1'b0;
    pe_tag = '0; pe_index = '0; val_out = '0; mod_out = '0; lru = '0; tag_out = '0;
    mm_rd = '0; resp_en = 1'b1; inj_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    outputs_zero("reset_state");
    tick();
    reset = 1'b0;
    tick();

    // Cold read miss, a=0x0004_0020
    do_miss(1'b0, 14'h1, 13'h1, 4'b0000, 4'b0000, 3'b000, 56'h0,
            {8{32'hA5A5_0001}}, 4'b0001, 1'b0, 32'h0, 32'h0004_0020, 7);
    tick();

    // Dirty eviction of way 2, tag 0x155
    do_miss(1'b0, 14'h0AA, 13'h1, 4'b1111, 4'b0100, 3'b001,
            {14'h0003, 14'h0155, 14'h0002, 14'h0001},
            {8{32'h5A5A_0002}}, 4'b0100, 1'b1, 32'h0554_0020, 32'h02A8_0020, 11);
    tick();

    // Write miss allocate into first invalid way (2)
    do_miss(1'b1, 14'h3, 13'h10, 4'b0011, 4'b0011, 3'b000, 56'h0,
            {8{32'hDEAD_0003}}, 4'b0100, 1'b0, 32'h0, 32'h000C_0200, 7);
    tick();

    // PLRU decode with all ways valid and clean
    for (int k = 0; k < 4; k++) begin
      do_miss(1'b0, 14'h7, 13'h20, 4'b1111, 4'b0000, lru_tab[k], 56'h0,
              {8{32'h1234_0000 + 32'(k)}}, way_tab[k], 1'b0, 32'h0, 32'h001C_0400, 7);
      tick();
    end

    // Reset while FILL is outstanding; a late mm_valid must be ignored
    resp_en = 1'b0;
    push_stall();
    push_mm(1'b1, 32'h0004_0020, 4'b0000, 2);
    pe_access = 1'b1; pe_read = 1'b1; pe_write = 1'b0; req_hit = 1'b0;
    pe_tag = 14'h1; pe_index = 13'h1; val_out = 4'b0000; mod_out = 4'b0000;
    mm_rd = {8{32'hBAD0_BAD0}};
    tick();
    tick();
    reset = 1'b1;
    pe_access = 1'b0; pe_read = 1'b0;
    tick();
    reset = 1'b0;
    inj_valid = 1'b1;
    @(negedge clk);
    outputs_zero("after_reset");
    tick();
    inj_valid = 1'b0;
    @(negedge clk);
    check("late_valid_writes", 256'({fsm_cc_ary_write, fsm_cc_tag_write, fsm_bit_cmd_valid}), 256'(0));
    resp_en = 1'b1;
    tick();

    // Back-to-back read hits
    pe_access = 1'b1; pe_read = 1'b1; req_hit = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pe_index = 13'(k);
      @(negedge clk);
      check("hit_stream", 256'({stall, mm_read, mm_write}), 256'(0));
      tick();
    end
    pe_access = 1'b0; pe_read = 1'b0; req_hit = 1'b0;

    repeat (3) tick();
    check("queue_empty", 256'(exp_q.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
